// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_pkg
// Description : Shared types and constants for the byte-serial wide ALU:
//               operation codes, controller states, 8-bit ALU select codes
//               and the per-byte select helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_CMP = 3'd2,
    OP_AND = 3'd3,
    OP_OR  = 3'd4,
    OP_XOR = 3'd5,
    OP_LSL = 3'd6,
    OP_LSR = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  localparam logic [3:0] SEL_ADD  = 4'd0;
  localparam logic [3:0] SEL_ADDC = 4'd1;
  localparam logic [3:0] SEL_SUB  = 4'd2;
  localparam logic [3:0] SEL_SUBC = 4'd3;
  localparam logic [3:0] SEL_AND  = 4'd5;
  localparam logic [3:0] SEL_OR   = 4'd6;
  localparam logic [3:0] SEL_XOR  = 4'd7;
  localparam logic [3:0] SEL_LSL  = 4'd9;
  localparam logic [3:0] SEL_LSR  = 4'd10;

  // Arithmetic ops use the plain form on the first byte and the
  // carry-chained form on every later byte.
  function automatic logic [3:0] sel_for(input op_e op, input logic first);
    logic [3:0] sel;
    sel = SEL_ADD;
    case (op)
      OP_ADD:         sel = first ? SEL_ADD : SEL_ADDC;
      OP_SUB, OP_CMP: sel = first ? SEL_SUB : SEL_SUBC;
      OP_AND:         sel = SEL_AND;
      OP_OR:          sel = SEL_OR;
      OP_XOR:         sel = SEL_XOR;
      OP_LSL:         sel = SEL_LSL;
      OP_LSR:         sel = SEL_LSR;
      default:        sel = SEL_ADD;
    endcase
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_wide_seq_alu8.sv
`default_nettype none
// ============================================================================
// Module      : alu_wide_seq_alu8
// Description : Combinational 8-bit ALU slice used once per byte.
// Ports       : SEL    - operation select (see SEL_* codes)
//               A, B   - 8-bit operands
//               CIN    - carry/borrow/shift-in bit
//               RESULT - 8-bit result
//               C      - carry out / borrow out / shifted-out bit
//               Z      - high when RESULT is zero
// Revision    : 1.0 - initial release
// ============================================================================
module alu_wide_seq_alu8
  import alu_seq_pkg::*;
(
  input  logic [3:0] SEL,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       CIN,
  output logic [7:0] RESULT,
  output logic       C,
  output logic       Z
);

  logic [8:0] ext;

  always_comb begin
    ext    = 9'd0;
    RESULT = 8'd0;
    C      = 1'b0;
    case (SEL)
      SEL_ADD:  ext = {1'b0, A} + {1'b0, B};
      SEL_ADDC: ext = {1'b0, A} + {1'b0, B} + {8'd0, CIN};
      // 9-bit wraparound leaves the borrow in bit 8.
      SEL_SUB:  ext = {1'b0, A} - {1'b0, B};
      SEL_SUBC: ext = {1'b0, A} - {1'b0, B} - {8'd0, CIN};
      SEL_AND:  ext = {1'b0, A & B};
      SEL_OR:   ext = {1'b0, A | B};
      SEL_XOR:  ext = {1'b0, A ^ B};
      SEL_LSL:  ext = {A, CIN};
      SEL_LSR:  ext = {A[0], CIN, A[7:1]};
      default:  ext = 9'd0;
    endcase
    RESULT = ext[7:0];
    C      = ext[8];
  end

  assign Z = (RESULT == 8'd0);

endmodule
`default_nettype wire

// File: rtl/alu_wide_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_wide_seq
// Description : Byte-serial wide ALU. Operands are latched on START and
//               pushed one byte per cycle through a single 8-bit ALU; the
//               carry and zero state are chained across bytes.
// Ports       : CLK    - clock, rising edge
//               RST    - asynchronous active-high reset
//               START  - request, sampled only while idle
//               OP     - operation code (op_e)
//               A, B   - 8*NBYTES-bit operands
//               BUSY   - high in RUN and FIN
//               DONE   - one-cycle completion pulse
//               RESULT - registered wide result
//               C, Z   - registered carry/borrow and zero flags
// Revision    : 1.0 - initial release
// ============================================================================
module alu_wide_seq
  import alu_seq_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [2:0]            OP,
  input  logic [8*NBYTES-1:0]   A,
  input  logic [8*NBYTES-1:0]   B,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [8*NBYTES-1:0]   RESULT,
  output logic                  C,
  output logic                  Z
);

  localparam int W    = 8 * NBYTES;
  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  state_e          state;
  logic [IDXW-1:0] idx;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  op_e             op_q;
  logic            carry_q;
  logic [W-1:0]    res_q;
  logic            zacc_q;

  logic [IDXW-1:0] byte_sel;
  logic [3:0]      alu_sel;
  logic [7:0]      alu_a;
  logic [7:0]      alu_b;
  logic [7:0]      alu_res;
  logic            alu_c;
  logic            alu_z;
  logic [W-1:0]    res_next;

  // Right shifts move bits downward, so the carry chain must start at the MSB.
  assign byte_sel = (op_q == OP_LSR) ? (LAST_IDX - idx) : idx;
  assign alu_sel  = sel_for(op_q, idx == '0);
  assign alu_a    = a_q[{byte_sel, 3'b000} +: 8];
  assign alu_b    = b_q[{byte_sel, 3'b000} +: 8];

  // Result register with the current byte merged in, so the last byte is
  // already included when the outputs are loaded on entering FIN.
  always_comb begin
    res_next = res_q;
    res_next[{byte_sel, 3'b000} +: 8] = alu_res;
  end

  alu_wide_seq_alu8 u_alu8 (
    .SEL    (alu_sel),
    .A      (alu_a),
    .B      (alu_b),
    .CIN    (carry_q),
    .RESULT (alu_res),
    .C      (alu_c),
    .Z      (alu_z)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      idx     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_ADD;
      carry_q <= 1'b0;
      res_q   <= '0;
      zacc_q  <= 1'b1;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      RESULT  <= '0;
      C       <= 1'b0;
      Z       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            a_q     <= A;
            b_q     <= B;
            op_q    <= op_e'(OP);
            idx     <= '0;
            carry_q <= 1'b0;
            zacc_q  <= 1'b1;
            BUSY    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          carry_q <= alu_c;
          res_q   <= res_next;
          zacc_q  <= zacc_q & alu_z;
          if (idx == LAST_IDX) begin
            idx   <= '0;
            state <= FIN;
            DONE  <= 1'b1;
            // Logic ops return C=0 from the slice, so no special case here.
            C     <= alu_c;
            Z     <= zacc_q & alu_z;
            if (op_q != OP_CMP) begin
              RESULT <= res_next;
            end
          end else begin
            idx <= idx + 1'b1;
          end
        end
        FIN: begin
          DONE  <= 1'b0;
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
          DONE  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
